// File: rtl/spike_synapse_integrator.sv
// Synaptic current integrator: per timestep, decays the held Q8.8 current and adds the weights
// of spiking presynaptic channels one channel per cycle, saturating at every add.
module spike_synapse_integrator #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned AW          = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     spike_in_i,
  input  logic                step_i,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [15:0]         wr_data_i,
  output logic                wr_ready_o,
  output logic signed [15:0]  i_syn_o,
  output logic                i_valid_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {StIdle, StDecay, StAccum, StDone} state_e;

  state_e             state_q;
  logic [N_IN-1:0]    spike_lat_q;
  logic [IW-1:0]      idx_q;
  logic signed [15:0] acc_q;
  logic signed [15:0] i_syn_q;
  logic               i_valid_q;
  logic               overrun_q;
  logic signed [15:0] weight_q [N_IN];

  logic signed [15:0] w_sel;
  logic               spk_sel;
  logic [16:0]        sum17;
  logic signed [15:0] sat_sum;
  logic signed [15:0] decayed;

  always_comb begin
    w_sel   = '0;
    spk_sel = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IW'(i)) begin
        w_sel   = weight_q[i];
        spk_sel = spike_lat_q[i];
      end
    end
  end

  // 17-bit sum overflows exactly when its top two bits disagree.
  always_comb begin
    sum17 = {acc_q[15], acc_q} + {w_sel[15], w_sel};
    if (sum17[16] != sum17[15]) begin
      sat_sum = sum17[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      sat_sum = sum17[15:0];
    end
    decayed = i_syn_q - (i_syn_q >>> DECAY_SHIFT);
  end

  assign busy_o     = (state_q != StIdle);
  assign wr_ready_o = !busy_o;
  assign i_syn_o    = i_syn_q;
  assign i_valid_o  = i_valid_q;
  assign overrun_o  = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      spike_lat_q <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      i_syn_q     <= '0;
      i_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      if (step_i && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (step_i) begin
            spike_lat_q <= spike_in_i;
            state_q     <= StDecay;
          end
        end
        StDecay: begin
          acc_q   <= decayed;
          idx_q   <= '0;
          state_q <= StAccum;
        end
        StAccum: begin
          if (spk_sel) begin
            acc_q <= sat_sum;
          end
          if (idx_q == IW'(N_IN - 1)) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          i_syn_q   <= acc_q;
          i_valid_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Writes are only accepted in idle, so weights stay frozen across a timestep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= '0;
      end
    end else if (wr_en_i && wr_ready_o) begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_addr_i == AW'(i)) begin
          weight_q[i] <= wr_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_synapse_integrator.sv
// Directed bench for spike_synapse_integrator: expected currents are queued when a step is driven
// and compared, with latency, when I_valid pulses.
module tb_spike_synapse_integrator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  spike_in = '0;
  logic        step = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [15:0] i_syn;
  logic        i_valid;
  logic        busy;
  logic        overrun;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  spike_synapse_integrator #(
    .N_IN        (4),
    .DECAY_SHIFT (3),
    .AW          (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in_i (spike_in),
    .step_i     (step),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .i_syn_o    (i_syn),
    .i_valid_o  (i_valid),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && i_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, i_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("i_syn", {16'd0, i_syn}, {16'd0, mon_e.val});
        chk("latency", cyc, mon_e.due);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_i_syn", {16'd0, i_syn}, 32'd0);
    chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && (sb.size() != 0 || busy); i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic do_step(input logic [3:0] spk, input logic [15:0] exp,
                         input logic we = 1'b0, input logic [1:0] wa = '0,
                         input logic [15:0] wd = '0);
    @(negedge clk);
    sb.push_back('{exp, cyc + 7});
    step = 1'b1;
    spike_in = spk;
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    @(negedge clk);
    step = 1'b0;
    wr_en = 1'b0;
    spike_in = ~spk;
    wait_done();
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("por_i_syn", {16'd0, i_syn}, 32'd0);
    chk("por_i_valid", {31'd0, i_valid}, 32'd0);
    chk("por_busy", {31'd0, busy}, 32'd0);
    chk("por_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("por_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Accumulation and decay.
    do_write(2'd0, 16'h0200);
    do_write(2'd1, 16'h0100);
    do_step(4'b0011, 16'h0300);
    do_step(4'b0000, 16'h02a0);
    do_step(4'b0000, 16'h024c);

    // Saturation.
    do_reset();
    for (int i = 0; i < 4; i++) do_write(2'(i), 16'h7000);
    do_step(4'b1111, 16'h7fff);
    do_reset();
    for (int i = 0; i < 4; i++) do_write(2'(i), 16'h9000);
    do_step(4'b1111, 16'h8000);
    do_reset();
    do_write(2'd0, 16'h7000);
    do_write(2'd1, 16'h7000);
    do_write(2'd2, 16'h9000);
    do_step(4'b0111, 16'h0fff);

    // Step while busy is ignored and flagged.
    @(negedge clk);
    chk("overrun_pre", {31'd0, overrun}, 32'd0);
    sb.push_back('{16'h0e00, cyc + 7});
    step = 1'b1;
    spike_in = 4'b0000;
    @(negedge clk);
    step = 1'b0;
    spike_in = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    step = 1'b1;
    #1;
    chk("busy_accum", {31'd0, busy}, 32'd1);
    chk("wr_ready_accum", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    step = 1'b0;
    #1;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    wait_done();
    repeat (10) @(negedge clk);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Write held during busy lands on the first idle edge.
    @(negedge clk);
    sb.push_back('{16'h7c40, cyc + 7});
    step = 1'b1;
    spike_in = 4'b0001;
    @(negedge clk);
    step = 1'b0;
    spike_in = 4'b0000;
    wr_en = 1'b1;
    wr_addr = 2'd0;
    wr_data = 16'h0100;
    #1;
    chk("wr_ready_busy", {31'd0, wr_ready}, 32'd0);
    for (int i = 0; i < 20 && !wr_ready; i++) begin
      @(negedge clk);
      #1;
    end
    chk("wr_ready_idle", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1 wr_en = 1'b0;
    wait_done();
    do_step(4'b0001, 16'h6db8);

    // Reset in the middle of accumulation.
    @(negedge clk);
    sb.push_back('{16'h1234, cyc + 7});
    step = 1'b1;
    spike_in = 4'b1111;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    do_reset();
    do_step(4'b1111, 16'h0000);

    // Decay floor; first step also writes the weight on the accepting edge.
    do_step(4'b0001, 16'h0007, 1'b1, 2'd0, 16'h0007);
    do_step(4'b0000, 16'h0007);
    do_reset();
    do_step(4'b0001, 16'hffff, 1'b1, 2'd0, 16'hffff);
    do_step(4'b0000, 16'h0000);
    do_reset();
    do_step(4'b0001, 16'hfff0, 1'b1, 2'd0, 16'hfff0);
    do_step(4'b0000, 16'hfff2);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
